mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter and sequencer for the byte-addressed data RAM in the pipelined CPU. It accepts load/store requests from the MEM stage (port 0) and from the debug/loader port (port 1), and grants one request at a time. It drives the RAM control lines for exactly one cycle per access and returns load data or a store completion to the winning port. It also rejects misaligned half/word accesses, which the RAM would otherwise silently align.

## Interface
- AW, 32, address width of requester and RAM address buses
- DW, 32, data width
- clk  in  1  rising-edge clock
- CLR  in  1  asynchronous, active-high reset
- pN_req  in  1  request, N∈{0,1}; held with its fields until pN_gnt
- pN_we  in  1  1=store, 0=load
- pN_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- pN_uext  in  1  zero-extend byte/half loads (else sign-extend)
- pN_addr  in  AW  byte address
- pN_wdata  in  DW  store data (low bits used for byte/half)
- pN_gnt  out  1  one-cycle accept pulse; request fields captured this edge
- pN_done  out  1  one-cycle completion pulse for port N's accepted access
- rdata  out  DW  load result, valid only with a pN_done of a load
- err  out  1  valid with pN_done; 1 = misaligned or reserved size, access dropped
- busy  out  1  high in any state other than IDLE
- ram_addr, ram_wdata  out  AW/DW  RAM address / store data
- ram_we, ram_byte, ram_half, ram_uext  out  1  RAM MemWrite/Byte/Half/UnsignedExt_Mem
- ram_rdata  in  DW  RAM registered read data (valid the cycle after command)

## Operation
- FSM states: IDLE, CMD, RESP.
- IDLE: if any req, select winner; pN_gnt=1 combinationally for winner; capture owner, we, size, uext, addr, wdata; go to CMD. No req: stay, all pulses 0.
- CMD: if captured access illegal (size=11, half with addr[0]=1, word with addr[1:0]≠00): ram_* held inactive, go to RESP with err latched. Else drive ram_addr/ram_wdata/ram_uext; ram_byte=(size==00), ram_half=(size==01), ram_we=we. Store → pulse owner's done this cycle, err=0, return IDLE. Load → RESP.
- RESP: owner's done=1; rdata=ram_rdata (load) or 0 (error); err per latch; return IDLE.
- Outside CMD: ram_we=ram_byte=ram_half=ram_uext=0, ram_addr/ram_wdata hold last value. A word read is issued whenever the RAM is idle; it is harmless.
- Winner selection: see Configuration. The losing request stays pending and is not acknowledged.
- Requests arriving while busy wait; gnt is only ever asserted in IDLE.

## Timing
- Reset (async): state=IDLE, all outputs 0, rdata=0, round-robin pointer=0 (port 0 preferred).
- Store: gnt at cycle T, RAM write strobe and done at T+1, next grant possible at T+2.
- Load: gnt at T, RAM command at T+1, done+rdata at T+2, next grant at T+3.
- Illegal access: gnt at T, done+err at T+2, no RAM write ever strobed.
- Simultaneous req on both ports in IDLE: exactly one gnt.
- CLR mid-access: access abandoned, no done, in-flight store not committed if CLR precedes its CMD edge.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. Pointer flips to the non-winner after every grant, so a tie goes to the port not granted last.
- Undefined: fixed priority, port 0 always wins ties, no pointer register.

## Structure
- Shared package: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), FSM state enum, alignment-check function.
- One sub-module: mem_arb_pick (two-requester picker, pointer register under MEM_ARB_RR_EN).

## Test plan
- Port 0 store word 0xDEADBEEF @0x8, then load word @0x8 → ram_we pulse at T+1; load done at T+2 with rdata=0xDEADBEEF, err=0.
- Port 1 byte load @0x3 with uext=0, RAM returns 0xFFFFFF80 → p1_done, rdata=0xFFFFFF80; ram_byte=1, ram_half=0 during CMD.
- Half store @0x5 → p0_done with err=1 two cycles after gnt; ram_we never asserted; a subsequent load @0x4 shows memory unchanged.
- Both ports req continuously, with RR enabled → grants alternate 0,1,0,1. With RR disabled → port 0 granted every time, port 1 never.
- CLR asserted the cycle after a load gnt → all outputs 0 immediately, no done; a fresh load after release completes normally.
- Request held during busy → gnt only once FSM is in IDLE, and fields captured at that edge are used (change addr while waiting, verify the final value is used).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: size codes, FSM states,
// captured-request payload and the alignment check.
package mem_port_arbiter_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          uext;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  // Reserved size, or half/word not naturally aligned.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] a_lo);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && a_lo[0]) ||
           ((size == SZ_WORD) && (a_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-requester winner picker. With MEM_ARB_RR_EN a pointer register tracks
// the preferred port; otherwise port 0 always wins a tie.
module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic i_adv,
`endif
  input  logic i_req0,
  input  logic i_req1,
  output logic o_pick0,
  output logic o_pick1
);

  logic w_pref1;

`ifdef MEM_ARB_RR_EN
  logic r_ptr;

  // After a grant the other port becomes preferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_adv) begin
      r_ptr <= o_pick0;
    end
  end

  assign w_pref1 = r_ptr;
`else
  assign w_pref1 = 1'b0;
`endif

  assign o_pick1 = i_req1 & (~i_req0 | w_pref1);
  assign o_pick0 = i_req0 & (~i_req1 | ~w_pref1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port load/store arbiter and sequencer for the byte-addressed data RAM.
// Tie-break policy: round-robin when MEM_ARB_RR_EN is defined, else fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          CLR,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [1:0]    p0_size,
  input  logic          p0_uext,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [1:0]    p1_size,
  input  logic          p1_uext,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_done,
  output logic          p1_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_byte,
  output logic          ram_half,
  output logic          ram_uext,
  input  logic [DW-1:0] ram_rdata
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_owner;
  logic       r_err;
  acc_t       r_acc;
  acc_t       w_acc_in;
  logic       w_pick0;
  logic       w_pick1;
  logic       w_grant_ok;
  logic       w_bad;
  logic       w_cmd_ok;
  logic       w_done;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk     (clk),
    .rst     (CLR),
    .i_adv   (p0_gnt | p1_gnt),
`endif
    .i_req0  (p0_req),
    .i_req1  (p1_req),
    .o_pick0 (w_pick0),
    .o_pick1 (w_pick1)
  );

  // Grants only leave IDLE, and never while reset is held.
  assign w_grant_ok = (r_state == ST_IDLE) && !CLR;
  assign p0_gnt     = w_grant_ok & w_pick0;
  assign p1_gnt     = w_grant_ok & w_pick1;

  assign w_acc_in = p1_gnt ? {p1_we, p1_size, p1_uext, p1_addr, p1_wdata}
                           : {p0_we, p0_size, p0_uext, p0_addr, p0_wdata};
  assign w_bad    = is_illegal(r_acc.size, r_acc.addr[1:0]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (p0_req || p1_req) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_bad || !r_acc.we) w_state_nxt = ST_RESP;
        else                    w_state_nxt = ST_IDLE;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (p0_gnt || p1_gnt) begin
        r_owner <= p1_gnt;
        r_acc   <= w_acc_in;
      end
      if (r_state == ST_CMD) begin
        r_err <= w_bad;
      end
    end
  end

  // RAM strobes live only in a legal CMD cycle; address/data hold otherwise.
  assign w_cmd_ok  = (r_state == ST_CMD) && !w_bad;
  assign ram_we    = w_cmd_ok & r_acc.we;
  assign ram_byte  = w_cmd_ok & (r_acc.size == SZ_BYTE);
  assign ram_half  = w_cmd_ok & (r_acc.size == SZ_HALF);
  assign ram_uext  = w_cmd_ok & r_acc.uext;
  assign ram_addr  = r_acc.addr;
  assign ram_wdata = r_acc.wdata;

  assign w_done  = (w_cmd_ok && r_acc.we) || (r_state == ST_RESP);
  assign p0_done = w_done & ~r_owner;
  assign p1_done = w_done & r_owner;
  assign err     = (r_state == ST_RESP) & r_err;
  assign rdata   = ((r_state == ST_RESP) && !r_err) ? ram_rdata : '0;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte-array RAM environment plus a
// byte-level reference memory used to predict every completion.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk, CLR;
  logic        p0_req, p0_we, p0_uext, p1_req, p1_we, p1_uext;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, err, busy;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_byte, ram_half, ram_uext;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_arr   [0:255];
  logic [7:0] model_mem [0:255];

  mem_port_arbiter dut (
    .clk(clk), .CLR(CLR),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uext(p0_uext),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uext(p1_uext),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .rdata(rdata), .err(err), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_byte(ram_byte), .ram_half(ram_half), .ram_uext(ram_uext),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // RAM environment: registered read, byte/half/word write.
  always @(posedge clk) begin
    logic [7:0] a;
    logic [31:0] raw;
    a = ram_addr[7:0];
    if (ram_we) begin
      ram_arr[a] <= ram_wdata[7:0];
      if (!ram_byte) ram_arr[8'(a + 8'd1)] <= ram_wdata[15:8];
      if (!ram_byte && !ram_half) begin
        ram_arr[8'(a + 8'd2)] <= ram_wdata[23:16];
        ram_arr[8'(a + 8'd3)] <= ram_wdata[31:24];
      end
    end
    raw = {ram_arr[8'(a + 8'd3)], ram_arr[8'(a + 8'd2)], ram_arr[8'(a + 8'd1)], ram_arr[a]};
    if (ram_byte)      ram_rdata <= ram_uext ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    else if (ram_half) ram_rdata <= ram_uext ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
    else               ram_rdata <= raw;
  end

  // Reference model ------------------------------------------------------
  function automatic bit model_illegal(input int size, input int addr);
    return (size == 3) || (size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0);
  endfunction

  function automatic int nbytes(input int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int addr, input int size, input bit uext);
    longint v = 0;
    longint scale = 1;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) begin
      v += longint'(model_mem[addr + i]) * scale;
      scale *= 256;
    end
    if (!uext && n < 4 && v >= scale / 2) v -= scale;
    return 32'(v);
  endfunction

  task automatic model_store(input int addr, input int size, input logic [31:0] d);
    longint v = longint'(d);
    for (int i = 0; i < nbytes(size); i++) begin
      model_mem[addr + i] = 8'(v % 256);
      v /= 256;
    end
  endtask

  // Driver/observer: one access on one port, no judging.
  task automatic access(input int port, input logic we, input logic [1:0] size,
                        input logic uext, input logic [31:0] addr, input logic [31:0] wdata,
                        output int gnt_lat, output int done_lat, output logic err_o,
                        output logic [31:0] rdata_o, output int we_cnt, output int stray,
                        output logic cmd_byte, output logic cmd_half);
    gnt_lat = -1; done_lat = -1; err_o = 1'b0; rdata_o = '0;
    we_cnt = 0; stray = 0; cmd_byte = 1'b0; cmd_half = 1'b0;
    @(negedge clk);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_size = size; p0_uext = uext; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_size = size; p1_uext = uext; p1_addr = addr; p1_wdata = wdata;
    end
    for (int c = 0; c < 20; c++) begin
      #1;
      if ((port == 0) ? p0_gnt : p1_gnt) begin
        gnt_lat = c;
        break;
      end
      @(negedge clk);
    end
    if (gnt_lat < 0) begin
      p0_req = 1'b0; p1_req = 1'b0;
      return;
    end
    for (int d = 1; d <= 6; d++) begin
      @(negedge clk);
      p0_req = 1'b0; p1_req = 1'b0;
      #1;
      if (ram_we) we_cnt++;
      if (d == 1) begin cmd_byte = ram_byte; cmd_half = ram_half; end
      if ((port == 0) ? p1_done : p0_done) stray++;
      if (p0_gnt || p1_gnt) stray++;
      if ((port == 0) ? p0_done : p1_done) begin
        done_lat = d; err_o = err; rdata_o = rdata;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    CLR = 1'b1;
    @(negedge clk);
    @(negedge clk);
    CLR = 1'b0;
  endtask

  // Tests ----------------------------------------------------------------
  task automatic test_reset();
    logic [15:0] flags;
    CLR = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    flags = {p0_gnt, p1_gnt, p0_done, p1_done, err, busy, ram_we, ram_byte, ram_half, ram_uext, 6'b0};
    checks++;
    if (flags !== 16'h0) begin errors++; $display("FAIL reset_flags got %h exp 0000", flags); end
    checks++;
    if ({rdata, ram_addr, ram_wdata} !== 96'h0) begin
      errors++; $display("FAIL reset_buses got %h/%h/%h exp 0", rdata, ram_addr, ram_wdata);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    CLR = 1'b0;
  endtask

  task automatic test_store_load();
    int gl, dl, wc, st; logic e, cb, ch; logic [31:0] rd;
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, gl, dl, e, rd, wc, st, cb, ch);
    model_store(8, 2, 32'hDEADBEEF);
    checks++; if (gl !== 0) begin errors++; $display("FAIL st_gnt_lat got %0d exp 0", gl); end
    checks++; if (dl !== 1) begin errors++; $display("FAIL st_done_lat got %0d exp 1", dl); end
    checks++; if (wc !== 1 || e !== 1'b0) begin errors++; $display("FAIL st_we_err got we=%0d err=%b exp 1/0", wc, e); end
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, gl, dl, e, rd, wc, st, cb, ch);
    checks++; if (dl !== 2) begin errors++; $display("FAIL ld_done_lat got %0d exp 2", dl); end
    checks++;
    if (rd !== model_load(8, 2, 1'b0) || e !== 1'b0) begin
      errors++; $display("FAIL ld_rdata got %h err=%b exp %h err=0", rd, e, model_load(8, 2, 1'b0));
    end
    checks++; if (wc !== 0 || st !== 0) begin errors++; $display("FAIL ld_we_stray got %0d/%0d exp 0/0", wc, st); end
  endtask

  task automatic test_byte_load();
    int gl, dl, wc, st; logic e, cb, ch; logic [31:0] rd;
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'h3, 32'h5A5A5A80, gl, dl, e, rd, wc, st, cb, ch);
    model_store(3, 0, 32'h5A5A5A80);
    checks++; if (dl !== 1 || wc !== 1) begin errors++; $display("FAIL bst got lat=%0d we=%0d exp 1/1", dl, wc); end
    access(1, 1'b0, SZ_BYTE, 1'b0, 32'h3, 32'h0, gl, dl, e, rd, wc, st, cb, ch);
    checks++;
    if (rd !== 32'hFFFFFF80 || rd !== model_load(3, 0, 1'b0) || dl !== 2) begin
      errors++; $display("FAIL bld_sext got %h lat=%0d exp ffffff80 lat=2", rd, dl);
    end
    checks++; if (cb !== 1'b1 || ch !== 1'b0) begin errors++; $display("FAIL bld_strobes got byte=%b half=%b exp 1/0", cb, ch); end
    checks++; if (st !== 0) begin errors++; $display("FAIL bld_stray got %0d exp 0", st); end
    access(1, 1'b0, SZ_BYTE, 1'b1, 32'h3, 32'h0, gl, dl, e, rd, wc, st, cb, ch);
    checks++; if (rd !== model_load(3, 0, 1'b1)) begin errors++; $display("FAIL bld_uext got %h exp %h", rd, model_load(3, 0, 1'b1)); end
  endtask

  task automatic test_misaligned();
    int gl, dl, wc, st; logic e, cb, ch; logic [31:0] rd;
    access(0, 1'b1, SZ_HALF, 1'b0, 32'h5, 32'h0000ABCD, gl, dl, e, rd, wc, st, cb, ch);
    checks++; if (dl !== 2 || e !== 1'b1) begin errors++; $display("FAIL mis_half got lat=%0d err=%b exp 2/1", dl, e); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL mis_half_we got %0d exp 0", wc); end
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, gl, dl, e, rd, wc, st, cb, ch);
    checks++; if (rd !== model_load(4, 2, 1'b0) || e !== 1'b0) begin errors++; $display("FAIL mis_unchanged got %h exp %h", rd, model_load(4, 2, 1'b0)); end
    access(1, 1'b0, SZ_RSVD, 1'b0, 32'h8, 32'h0, gl, dl, e, rd, wc, st, cb, ch);
    checks++; if (dl !== 2 || e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rsvd got lat=%0d err=%b rd=%h exp 2/1/0", dl, e, rd); end
  endtask

  task automatic test_random();
    int gl, dl, wc, st, port, size, addr, exp_lat; logic e, cb, ch, we, uext, ill; logic [31:0] rd, wd, exp_rd;
    for (int i = 0; i < 40; i++) begin
      port = int'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      size = int'($urandom_range(0, 3)); uext = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 63)); wd = $urandom;
      ill = model_illegal(size, addr);
      exp_lat = (!ill && we) ? 1 : 2;
      exp_rd  = (!ill && !we) ? model_load(addr, size, uext) : 32'h0;
      access(port, we, 2'(size), uext, 32'(addr), wd, gl, dl, e, rd, wc, st, cb, ch);
      if (!ill && we) model_store(addr, size, wd);
      checks++;
      if (dl !== exp_lat || e !== ill || wc !== ((!ill && we) ? 1 : 0) || st !== 0) begin
        errors++; $display("FAIL rnd%0d_ctl got lat=%0d err=%b we=%0d stray=%0d exp lat=%0d err=%b", i, dl, e, wc, st, exp_lat, ill);
      end
      if (!(we && !ill)) begin
        checks++;
        if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", i, rd, exp_rd); end
      end
    end
  endtask

  task automatic test_arbitration();
    int n = 0, both = 0, busy_g = 0, exp_w;
    int seq [0:5];
    apply_reset();
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_size = SZ_WORD; p0_addr = 32'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_size = SZ_WORD; p1_addr = 32'h4;
    for (int c = 0; c < 60 && n < 6; c++) begin
      #1;
      if (p0_gnt && p1_gnt) both++;
      if (p0_gnt || p1_gnt) begin
        seq[n] = p1_gnt ? 1 : 0;
        if (busy) busy_g++;
        n++;
      end
      @(negedge clk);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    for (int k = 0; k < 8 && busy; k++) @(negedge clk);
    checks++; if (n !== 6 || both !== 0 || busy_g !== 0) begin errors++; $display("FAIL arb_count got n=%0d both=%0d busy=%0d exp 6/0/0", n, both, busy_g); end
    for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_w = i % 2;
`else
      exp_w = 0;
`endif
      checks++; if (seq[i] !== exp_w) begin errors++; $display("FAIL arb_seq%0d got %0d exp %0d", i, seq[i], exp_w); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_drain got busy=%b exp 0", busy); end
  endtask

  task automatic test_clr_mid();
    int gl, dl, wc, st, nd = 0; logic e, cb, ch; logic [31:0] rd;
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_size = SZ_WORD; p0_uext = 1'b0; p0_addr = 32'h8;
    #1; checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL clr_gnt got %b exp 1", p0_gnt); end
    @(negedge clk);
    p0_req = 1'b0; CLR = 1'b1;
    #1; checks++;
    if ({busy, p0_done, p1_done, err, ram_we, ram_byte, ram_half, ram_uext} !== 8'h0 || rdata !== 32'h0 || ram_addr !== 32'h0) begin
      errors++; $display("FAIL clr_outputs got busy=%b done=%b%b err=%b addr=%h exp all 0", busy, p0_done, p1_done, err, ram_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (p0_done || p1_done) nd++;
      if (k == 0) CLR = 1'b0;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL clr_no_done got %0d exp 0", nd); end
    // Store abandoned by reset during its command cycle.
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_size = SZ_WORD; p0_addr = 32'h10; p0_wdata = 32'h12345678;
    @(negedge clk);
    p0_req = 1'b0; CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
    access(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, gl, dl, e, rd, wc, st, cb, ch);
    checks++; if (rd !== model_load(16, 2, 1'b0) || dl !== 2) begin errors++; $display("FAIL clr_store_dropped got %h exp %h", rd, model_load(16, 2, 1'b0)); end
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, gl, dl, e, rd, wc, st, cb, ch);
    checks++; if (rd !== model_load(8, 2, 1'b0) || dl !== 2 || gl !== 0) begin errors++; $display("FAIL clr_fresh_load got %h lat=%0d exp %h lat=2", rd, dl, model_load(8, 2, 1'b0)); end
  endtask

  task automatic test_held_during_busy();
    int gl, dl, wc, st, early = 0, gat = -1, dn = -1; logic e, cb, ch; logic [31:0] rd, rd1;
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11112222, gl, dl, e, rd, wc, st, cb, ch);
    model_store(32, 2, 32'h11112222);
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h24, 32'h33334444, gl, dl, e, rd, wc, st, cb, ch);
    model_store(36, 2, 32'h33334444);
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_size = SZ_WORD; p0_addr = 32'h8;
    @(negedge clk);
    p0_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_size = SZ_WORD; p1_uext = 1'b0; p1_addr = 32'h20;
    #1; if (p1_gnt) early++;
    @(negedge clk);
    p1_addr = 32'h24;
    #1; if (p1_gnt) early++;
    rd = rdata;
    checks++; if (p0_done !== 1'b1 || rd !== model_load(8, 2, 1'b0)) begin errors++; $display("FAIL held_p0 got done=%b rd=%h exp 1/%h", p0_done, rd, model_load(8, 2, 1'b0)); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (p1_gnt) begin
        gat = c;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_gnt_busy got %b exp 0", busy); end
        break;
      end
    end
    checks++; if (early !== 0 || gat !== 0) begin errors++; $display("FAIL held_gnt_time got early=%0d at=%0d exp 0/0", early, gat); end
    rd1 = '0;
    for (int d = 1; d <= 6; d++) begin
      @(negedge clk);
      p1_req = 1'b0;
      #1;
      if (p1_done) begin dn = d; rd1 = rdata; break; end
    end
    checks++; if (dn !== 2 || rd1 !== model_load(36, 2, 1'b0)) begin errors++; $display("FAIL held_final_addr got lat=%0d rd=%h exp 2/%h", dn, rd1, model_load(36, 2, 1'b0)); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_arr[i] = 8'h0;
      model_mem[i] = 8'h0;
    end
    CLR = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_size = 2'b00; p0_uext = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'b00; p1_uext = 1'b0; p1_addr = '0; p1_wdata = '0;
    test_reset();
    test_store_load();
    test_byte_load();
    test_misaligned();
    test_random();
    test_arbitration();
    test_clr_mid();
    test_held_during_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
